uart_tx_cfg: RTL and testbench

Runtime-configurable UART transmitter, the successor to the fixed 8N1 transmitter. It adds a buffered ready/valid input, programmable frame format (5–9 data bits, none/even/odd parity, 1 or 2 stop bits), and a runtime baud divisor. It sits between on-chip producers, such as CSR writes or a DMA, and the serial tx pin. It sends frames back-to-back while its FIFO holds data.

---
 rtl/uart_pkg.sv | 44 ++++
 rtl/uart_tx_cfg_if.sv | 19 +
 rtl/uart_tx_fifo.sv | 66 ++++++
 rtl/uart_tx_cfg.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the configurable UART transmitter and the matching
// receiver: parity mode encodings, FSM state encodings, data-bit clamp limits,
// and small helpers that turn raw configuration inputs into legal values.
// No ports (package).

package uart_pkg;

  // Width of the payload carried through the FIFO (largest frame is 9 bits).
  localparam int PAYLOAD_W = 9;

  // Legal range for the number of data bits per frame.
  localparam logic [3:0] DATA_BITS_MIN = 4'd5;
  localparam logic [3:0] DATA_BITS_MAX = 4'd9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Force a requested data-bit count into the supported 5..9 window.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] d);
    if (d < DATA_BITS_MIN) return DATA_BITS_MIN;
    if (d > DATA_BITS_MAX) return DATA_BITS_MAX;
    return d;
  endfunction

  // The reserved mode value 3 behaves like "no parity".
  function automatic parity_e decode_parity(input logic [1:0] m);
    if (m == 2'd1) return PAR_EVEN;
    if (m == 2'd2) return PAR_ODD;
    return PAR_NONE;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if
// Ready/valid word channel from an on-chip producer into the UART transmitter.
// Signals:
//   data  - frame payload, LSB sent first (PAYLOAD_W bits)
//   valid - producer presents a word
//   ready - transmitter can accept the word this cycle
// Modports: master (producer side), slave (transmitter side).

interface uart_tx_cfg_if;
  import uart_pkg::*;

  logic [PAYLOAD_W-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Small synchronous FIFO holding words waiting to be transmitted.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata  - write request and word; ignored while full
//   pop          - read request; ignored while empty
//   rdata        - word at the head (valid while not empty)
//   full, empty  - status derived from the registered occupancy
//   level        - number of words currently stored

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [PAYLOAD_W-1:0] wdata,
  input  logic                 pop,
  output logic [PAYLOAD_W-1:0] rdata,
  output logic                 full,
  output logic                 empty,
  output logic [LVL_W-1:0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LVL_W-1:0]     count;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == DEPTH_L);
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array; contents need no reset because the pointers and count
  // define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two; a simultaneous
  // push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + LVL_W'(1);
      else if (do_pop && !do_push) count <= count - LVL_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg
// Runtime-configurable UART transmitter with a buffered ready/valid input.
// Frame format (5..9 data bits, none/even/odd parity, 1 or 2 stop bits) and
// the baud divisor are captured when a word is popped from the FIFO, so
// configuration changes only affect frames that start afterwards.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   s           - producer channel (slave modport): data/valid in, ready out
//   baud_div    - clocks per bit, 0 behaves as 1
//   data_bits   - data bits per frame, clamped to 5..9
//   parity_mode - 0 none, 1 even, 2 odd, 3 none
//   stop2       - 1 selects two stop bits
//   tx          - registered serial output, idle high
//   busy        - a frame is in progress
//   fifo_level  - words waiting in the FIFO

module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_cfg_if.slave     s,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [3:0]       data_bits,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
  output logic             tx,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [PAYLOAD_W-1:0] head;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 load;

  state_e               state,    state_n;
  logic [DIV_W-1:0]     cnt,      cnt_n;
  logic [3:0]           bit_idx,  bit_idx_n;
  logic                 stop_idx, stop_idx_n;
  logic                 par_acc,  par_acc_n;
  logic [PAYLOAD_W-1:0] payload,  payload_n;
  logic [DIV_W-1:0]     div_m1,   div_m1_n;
  logic [3:0]           dbits,    dbits_n;
  parity_e              par,      par_n;
  logic                 two_stop, two_stop_n;
  logic                 tx_n;
  logic                 bit_end;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s.valid),
    .wdata (s.data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign s.ready = !full;

  // Comparing against the latched N-1 means the counter never runs past it.
  assign bit_end = (cnt == div_m1);

  // Next-state logic. A pop ("load") can happen from IDLE or at the end of
  // the last stop bit, which is what gives back-to-back frames with no gap.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    par_acc_n  = par_acc;
    payload_n  = payload;
    div_m1_n   = div_m1;
    dbits_n    = dbits;
    par_n      = par;
    two_stop_n = two_stop;
    load       = 1'b0;
    pop        = 1'b0;

    if (state != ST_IDLE) cnt_n = bit_end ? '0 : cnt + ONE;

    case (state)
      ST_IDLE: begin
        if (!empty) load = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_n   = ST_DATA;
          bit_idx_n = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          par_acc_n = par_acc ^ payload[bit_idx];
          if (bit_idx == dbits - 4'd1) begin
            state_n    = (par == PAR_NONE) ? ST_STOP : ST_PARITY;
            stop_idx_n = 1'b0;
          end else begin
            bit_idx_n = bit_idx + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_n    = ST_STOP;
          stop_idx_n = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (two_stop && !stop_idx) stop_idx_n = 1'b1;
          else if (!empty)           load       = 1'b1;
          else                       state_n    = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Capture the head word and the whole frame configuration together.
    if (load) begin
      pop        = 1'b1;
      state_n    = ST_START;
      cnt_n      = '0;
      payload_n  = head;
      div_m1_n   = (baud_div == '0) ? '0 : baud_div - ONE;
      dbits_n    = clamp_data_bits(data_bits);
      par_n      = decode_parity(parity_mode);
      two_stop_n = stop2;
      par_acc_n  = 1'b0;
    end
  end

  // The line level is computed from the next state so that tx can be a
  // plain register that only moves at bit boundaries.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = payload_n[bit_idx_n];
      ST_PARITY: tx_n = par_acc_n ^ (par_n == PAR_ODD);
      default:   tx_n = 1'b1;
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_acc  <= 1'b0;
      payload  <= '0;
      div_m1   <= '0;
      dbits    <= DATA_BITS_MIN;
      par      <= PAR_NONE;
      two_stop <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      par_acc  <= par_acc_n;
      payload  <= payload_n;
      div_m1   <= div_m1_n;
      dbits    <= dbits_n;
      par      <= par_n;
      two_stop <= two_stop_n;
      tx       <= tx_n;
      busy     <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg
// Self-checking bench for uart_tx_cfg. A queue-based model expands every
// popped word into its expected per-clock line waveform; a compare process
// checks tx, busy, fifo_level and ready against it on every cycle, and the
// directed tests pin the model with hand-computed frame patterns.

module tb_uart_tx_cfg;

  localparam int DIV_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [DIV_W-1:0] baud_div = 16'd1;
  logic [3:0]       data_bits = 4'd8;
  logic [1:0]       parity_mode = 2'd0;
  logic             stop2 = 1'b0;
  logic             tx;
  logic             busy;
  logic [LVL_W-1:0] fifo_level;

  int checks   = 0;
  int failures = 0;

  uart_tx_cfg_if bus ();

  uart_tx_cfg #(
    .DIV_W      (DIV_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LVL_W      (LVL_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s           (bus),
    .baud_div    (baud_div),
    .data_bits   (data_bits),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .tx          (tx),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  // Model state: queued words and the expected line level for each coming cycle.
  logic [8:0] mq[$];
  bit         wave[$];
  logic       exp_tx    = 1'b1;
  logic       exp_busy  = 1'b0;
  int         exp_level = 0;
  logic       model_on  = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expand one word into its frame using the currently applied configuration.
  task automatic buildFrame(input logic [8:0] w);
    int n, d, ones;
    bit seq[$];
    n    = (baud_div == 0) ? 1 : int'(baud_div);
    d    = (data_bits < 5) ? 5 : ((data_bits > 9) ? 9 : int'(data_bits));
    ones = 0;
    seq.push_back(1'b0);
    for (int i = 0; i < d; i++) begin
      seq.push_back(w[i]);
      if (w[i]) ones++;
    end
    if (parity_mode == 2'd1)      seq.push_back(ones % 2 == 1);
    else if (parity_mode == 2'd2) seq.push_back(ones % 2 == 0);
    seq.push_back(1'b1);
    if (stop2) seq.push_back(1'b1);
    foreach (seq[i])
      for (int k = 0; k < n; k++) wave.push_back(seq[i]);
  endtask

  // Model update on each clock edge, using values present before the edge.
  initial begin
    bit         accept;
    logic [8:0] w;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        wave.delete();
        exp_tx    = 1'b1;
        exp_busy  = 1'b0;
        exp_level = 0;
      end else begin
        accept = bus.valid && (mq.size() < FIFO_DEPTH);
        if (wave.size() == 0 && mq.size() != 0) begin
          w = mq.pop_front();
          buildFrame(w);
        end
        if (wave.size() != 0) begin
          exp_tx   = wave.pop_front();
          exp_busy = 1'b1;
        end else begin
          exp_tx   = 1'b1;
          exp_busy = 1'b0;
        end
        if (accept) mq.push_back(bus.data);
        exp_level = mq.size();
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_on && !rst) begin
        checkOutput("tx",         tx,         exp_tx);
        checkOutput("busy",       busy,       exp_busy);
        checkOutput("fifo_level", fifo_level, exp_level);
        checkOutput("s_ready",    bus.ready,  exp_level < FIFO_DEPTH);
      end
    end
  end

  task automatic setCfg(input int div, input int db, input int pm, input bit st2);
    baud_div    = DIV_W'(div);
    data_bits   = 4'(db);
    parity_mode = 2'(pm);
    stop2       = st2;
  endtask

  // Offer one word and hold it until an edge accepts it (bounded).
  task automatic applyStimulus(input logic [8:0] w);
    logic ok;
    int   guard;
    guard     = 0;
    bus.data  = w;
    bus.valid = 1'b1;
    do begin
      ok = bus.ready;
      @(posedge clk);
      #2;
      guard++;
    end while (!ok && guard < 200);
    bus.valid = 1'b0;
    checkOutput("push_accept", ok, 1'b1);
  endtask

  // Wait for busy, then sample tx mid-bit and measure how long busy stays high.
  task automatic captureFrame(input int n, input int nbits,
                              output logic [15:0] bits, output int len);
    int guard;
    bits  = '0;
    len   = 0;
    guard = 0;
    @(negedge clk);
    while (!busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("frame_start", busy, 1'b1);
    while (busy && len < 2000) begin
      if ((len % n) == n / 2 && (len / n) < nbits) bits[len / n] = tx;
      len++;
      @(negedge clk);
    end
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((busy || fifo_level != 0) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("idle_reached", busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    logic [15:0] bits;
    int          len;
    bus.data  = '0;
    bus.valid = 1'b0;

    // Reset values
    #3 rst = 1'b1;
    #1;
    checkOutput("reset_tx",    tx,         1'b1);
    checkOutput("reset_busy",  busy,       1'b0);
    checkOutput("reset_ready", bus.ready,  1'b1);
    checkOutput("reset_level", fifo_level, 0);
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    model_on = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1, N=4, 0xA5
    setCfg(4, 8, 0, 1'b0);
    applyStimulus(9'h0A5);
    captureFrame(4, 10, bits, len);
    checkOutput("a5_bits", bits[9:0], 10'h34A);
    checkOutput("a5_len",  len, 40);
    waitIdle();

    // 7E1, N=3, 0x1B5 (bits 7..8 ignored)
    setCfg(3, 7, 1, 1'b0);
    applyStimulus(9'h1B5);
    captureFrame(3, 10, bits, len);
    checkOutput("7e1_bits", bits[9:0], 10'h26A);
    checkOutput("7e1_len",  len, 30);
    waitIdle();

    // 9O2, N=2, 0x1FF
    setCfg(2, 9, 2, 1'b1);
    applyStimulus(9'h1FF);
    captureFrame(2, 13, bits, len);
    checkOutput("9o2_bits", bits[12:0], 13'h1BFE);
    checkOutput("9o2_len",  len, 26);
    waitIdle();

    // Divisor 0, data_bits 3 -> 5, parity mode 3 -> none
    setCfg(0, 3, 3, 1'b0);
    applyStimulus(9'h015);
    captureFrame(1, 7, bits, len);
    checkOutput("clamp_lo_bits", bits[6:0], 7'h6A);
    checkOutput("clamp_lo_len",  len, 7);
    waitIdle();

    // data_bits 15 -> 9, even parity, two stop bits
    setCfg(1, 15, 1, 1'b1);
    applyStimulus(9'h1C3);
    captureFrame(1, 13, bits, len);
    checkOutput("clamp_hi_bits", bits[12:0], 13'h1F86);
    checkOutput("clamp_hi_len",  len, 13);
    waitIdle();

    // FIFO fill while a frame is in flight, then a stalled fifth push
    setCfg(1, 8, 0, 1'b0);
    applyStimulus(9'h011);
    applyStimulus(9'h122);
    applyStimulus(9'h033);
    applyStimulus(9'h144);
    applyStimulus(9'h055);
    checkOutput("full_ready", bus.ready,  1'b0);
    checkOutput("full_level", fifo_level, 4);
    applyStimulus(9'h066);
    checkOutput("refill_level", fifo_level, 4);
    waitIdle();

    // data_bits changed 8 -> 5 while the first frame is running
    setCfg(2, 8, 0, 1'b0);
    applyStimulus(9'h0F0);
    applyStimulus(9'h00F);
    data_bits = 4'd5;
    captureFrame(2, 10, bits, len);
    checkOutput("cfgchg_bits", bits[9:0], 10'h3E0);
    checkOutput("cfgchg_len",  len, 34);
    waitIdle();

    // Reset during DATA of a 0x00 frame, then a fresh frame
    setCfg(4, 8, 0, 1'b0);
    applyStimulus(9'h000);
    applyStimulus(9'h055);
    repeat (8) @(negedge clk);
    checkOutput("pre_rst_busy", busy, 1'b1);
    checkOutput("pre_rst_tx",   tx,   1'b0);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_tx",    tx,         1'b1);
    checkOutput("rst_busy",  busy,       1'b0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_ready", bus.ready,  1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(9'h03C);
    captureFrame(4, 10, bits, len);
    checkOutput("post_rst_bits", bits[9:0], 10'h278);
    checkOutput("post_rst_len",  len, 40);
    waitIdle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
